// File: rtl/ex_pipeline_controller_if.sv
// Hazard inputs and pipeline-register strobes between the
// EX-stage controller (master) and the pipeline datapath (slave).
interface ex_pipeline_controller_if #(
  parameter int CNT_W = 16
);
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             muldiv_start;
  logic             branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  idex_mem_read, idex_rt,
    input  ifid_rs, ifid_rt, ifid_uses_rt,
    input  muldiv_start, branch_taken,
    output pc_write, ifid_write, ifid_flush,
    output idex_write, idex_bubble,
    output exmem_bubble, md_busy, md_done,
    output stall_cycles, flush_count
  );

  modport slave (
    output idex_mem_read, idex_rt,
    output ifid_rs, ifid_rt, ifid_uses_rt,
    output muldiv_start, branch_taken,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_write, idex_bubble,
    input  exmem_bubble, md_busy, md_done,
    input  stall_cycles, flush_count
  );
endinterface

// File: rtl/ex_pipeline_controller.sv
// EX-stage pipeline sequencer: load-use stalls, MEM branch
// flushes and mult/div freezes, with saturating statistics.
module ex_pipeline_controller #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  ex_pipeline_controller_if.master bus
);
  localparam int MD_W =
    (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam int MD_INIT =
    (MD_LAT > 1) ? MD_LAT - 2 : 0;
  localparam logic [MD_W-1:0] MD_LOAD =
    MD_W'(MD_INIT);

  typedef enum logic {
    RUN,
    MD_BUSY
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [MD_W-1:0]  cnt_q;
  logic [MD_W-1:0]  cnt_d;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_bubble;
  logic exmem_bubble;
  logic md_busy;
  logic md_done;
  logic flush_inc;

  logic load_use;
  logic rt_hit;
  logic br_go;
  logic md_go;
  logic lu_go;

  assign rt_hit = bus.ifid_uses_rt &&
    (bus.idex_rt == bus.ifid_rt);
  assign load_use = bus.idex_mem_read &&
    (bus.idex_rt != 5'd0) &&
    ((bus.idex_rt == bus.ifid_rs) || rt_hit);

  // Priority resolved up front so the decoder is one-hot.
  assign br_go = bus.branch_taken;
  assign md_go = bus.muldiv_start && !br_go;
  assign lu_go = load_use && !br_go && !md_go;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    flush_inc    = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          unique case (1'b1)
            br_go: begin
              ifid_flush   = 1'b1;
              idex_bubble  = 1'b1;
              exmem_bubble = 1'b1;
              flush_inc    = 1'b1;
            end
            md_go: begin
              if (MD_LAT > 1) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                md_busy      = 1'b1;
                cnt_d        = MD_LOAD;
                state_d      = MD_BUSY;
              end else begin
                md_done = 1'b1;
              end
            end
            lu_go: begin
              pc_write    = 1'b0;
              ifid_write  = 1'b0;
              idex_bubble = 1'b1;
            end
            default: begin
            end
          endcase
        end
        MD_BUSY: begin
          if (cnt_q != '0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            md_busy      = 1'b1;
            cnt_d        = cnt_q - 1'b1;
          end else begin
            md_done = 1'b1;
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (flush_inc && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_write   = idex_write;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_bubble = exmem_bubble;
  assign bus.md_busy      = md_busy;
  assign bus.md_done      = md_done;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
endmodule
